// File: rtl/rate_div_pkg.sv
// Shared constants for the rate divider.
// Holds the period floor and default widths.
package rate_div_pkg;

  localparam int MIN_PERIOD = 2;
  localparam int DEF_CNT_W  = 28;
  localparam int DEF_LVL_W  = 2;

endpackage

// File: rtl/rate_divider_if.sv
// Control/status bundle for the rate divider.
// The master drives controls; the slave returns tick and sq.
interface rate_divider_if
  import rate_div_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int LVL_W  = DEF_LVL_W
);

  logic                    en;
  logic                    sync_clr;
  logic [LVL_W-1:0]        level;
  logic [NUM_CH*CNT_W-1:0] div_val;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       sq;

  modport master (
    output en, sync_clr, level, div_val,
    input  tick, sq
  );

  modport slave (
    input  en, sync_clr, level, div_val,
    output tick, sq
  );

endinterface

// File: rtl/rate_divider_ch.sv
// One divider channel: period latched at period start,
// combinational tick, registered square wave.
module rate_divider_ch
  import rate_div_pkg::*;
#(
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LVL_W   = DEF_LVL_W,
  parameter bit USE_LVL = 1'b0
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             i_en,
  input  logic             i_sync_clr,
  input  logic [LVL_W-1:0] i_level,
  input  logic [CNT_W-1:0] i_div,
  output logic             o_tick,
  output logic             o_sq
);

  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic             r_sq;

  logic [CNT_W-1:0] w_shf;
  logic [CNT_W-1:0] w_preq;
  logic [CNT_W-1:0] w_per;
  logic [CNT_W-1:0] w_last;
  logic [CNT_W-1:0] w_half;
  logic             w_start;
  logic             w_wrap;

  assign w_shf   = USE_LVL ? (i_div >> i_level) : i_div;
  assign w_preq  = (w_shf < MINP) ? MINP : w_shf;
  assign w_start = (r_cnt == '0);
  // At period start the fresh request governs this period
  assign w_per   = w_start ? w_preq : r_per;
  assign w_last  = w_per - ONE;
  assign w_half  = w_per >> 1;
  assign w_wrap  = (r_cnt == w_last);

  assign o_tick = i_en & w_wrap;
  assign o_sq   = r_sq;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_cnt <= '0;
      r_per <= MINP;
      r_sq  <= 1'b0;
    end else if (i_sync_clr) begin
      r_cnt <= '0;
      r_sq  <= 1'b1;
    end else if (i_en) begin
      if (w_start) r_per <= w_preq;
      r_sq  <= (r_cnt < w_half);
      r_cnt <= w_wrap ? '0 : r_cnt + ONE;
    end
  end

endmodule

// File: rtl/rate_divider.sv
// Multi-channel clock-enable rate divider.
// Each channel divides clk by its own (optionally level-scaled) period.
module rate_divider
  import rate_div_pkg::*;
#(
  parameter int              NUM_CH   = 4,
  parameter int              CNT_W    = DEF_CNT_W,
  parameter int              LVL_W    = DEF_LVL_W,
  parameter logic [NUM_CH-1:0] LVL_MASK = '0
) (
  input  logic         clk,
  input  logic         clr_n,
  rate_divider_if.slave bus
);

  logic [NUM_CH-1:0] w_tick;
  logic [NUM_CH-1:0] w_sq;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
    rate_divider_ch #(
      .CNT_W   (CNT_W),
      .LVL_W   (LVL_W),
      .USE_LVL (LVL_MASK[ch])
    ) u_ch (
      .clk        (clk),
      .clr_n      (clr_n),
      .i_en       (bus.en),
      .i_sync_clr (bus.sync_clr),
      .i_level    (bus.level),
      .i_div      (bus.div_val[ch*CNT_W +: CNT_W]),
      .o_tick     (w_tick[ch]),
      .o_sq       (w_sq[ch])
    );
  end

  assign bus.tick = w_tick;
  assign bus.sq   = w_sq;

endmodule

// File: doc/rate_divider.md
RATE_DIVIDER -- requirements
Module: rate_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels.
REQ-002 Parameter CNT_W, default 28: counter and divisor width per channel.
REQ-003 Parameter LVL_W, default 2: width of the level input.
REQ-004 Parameter LVL_MASK, default {NUM_CH{1'b0}}: bit ch=1 means the channel's period scales with level.
REQ-005 clk  input  1  master clock, 50 MHz; the only clock.
REQ-006 clr_n  input  1  reset, asynchronous, active-low.
REQ-007 en  input  1  global count enable; counters hold when low.
REQ-008 sync_clr  input  1  synchronous restart of all channels.
REQ-009 level  input  LVL_W  game level, used as a right-shift amount for masked channels.
REQ-010 div_val  input  NUM_CH*CNT_W  requested period in clk cycles per channel; channel ch occupies bits [ch*CNT_W +: CNT_W].
REQ-011 tick  output  NUM_CH  one-cycle pulse per completed period (clock enable).
REQ-012 sq  output  NUM_CH  registered square wave, one cycle per period.

Function
REQ-013 The effective period SHALL be P_req = div_val[ch] >> level if LVL_MASK[ch] = 1, else div_val[ch]; when P_req < 2 the period SHALL be 2.
REQ-014 Each channel SHALL hold cnt (CNT_W bits) and a latched period per_q; P_req SHALL be sampled into per_q only on an enabled cycle where cnt = 0, that is, at period start.
REQ-015 Changes to div_val or level mid-period SHALL NOT alter the running period; they SHALL take effect from the next period start, with no shortened or stretched period.
REQ-016 On an enabled cycle, cnt SHALL increment; when cnt = per - 1, the next value of cnt SHALL be 0 (wrap).
REQ-017 tick[ch] SHALL be high exactly during the cycle in which cnt = per - 1 and en = 1, and low otherwise.
REQ-018 sq[ch] SHALL be a flop output: high for the first floor(per/2) cycles of each period and low for the remaining ceil(per/2); odd periods give the extra cycle to the low phase.
REQ-019 With en = 0, cnt, per_q and sq SHALL hold, and tick SHALL be 0.
REQ-020 With sync_clr = 1, all channels SHALL set cnt to 0 and tick to 0 on the next edge, and sq SHALL be 1 from the next edge; this applies regardless of en (sync_clr wins).
REQ-021 After sync_clr the next enabled cycle SHALL start a new period with a fresh P_req sample.
REQ-022 Arithmetic SHALL be unsigned at CNT_W bits with no overflow; div_val = 2^CNT_W - 1 is legal.
REQ-023 Channels SHALL be fully independent; equal divisors give phase-aligned ticks after reset or sync_clr.

Reset
REQ-024 While clr_n = 0, all cnt = 0, per_q = 2, tick = 0 and sq = 0, applied asynchronously.
REQ-025 The first enabled cycle after clr_n deasserts SHALL be a period start (cnt = 0) and SHALL sample P_req.
REQ-026 sq SHALL go high on the first enabled edge after reset.

Structure
REQ-027 Package rate_div_pkg SHALL hold MIN_PERIOD = 2 and the default CNT_W and LVL_W.
REQ-028 One sub-module, rate_divider_ch, SHALL implement a single channel; the top SHALL generate NUM_CH instances and slice div_val per channel.
REQ-029 No derived or gated clocks SHALL be produced; tick is used as a clock enable downstream.

Verification
REQ-030 Period: div_val = 5, en = 1 -> tick on cycles 5, 10, 15 after reset release; sq pattern per period 1,1,0,0,0.
REQ-031 Level: LVL_MASK[1] = 1, div_val = 16, level = 2 -> period 4; level changed to 0 at mid-period -> current period finishes at 4 cycles, next period is 16.
REQ-032 Clamp: div_val = 0 and div_val = 1, and div_val = 3 with level = 3 on a masked channel -> each gives tick every 2 cycles, sq alternating 1,0.
REQ-033 Enable and clear: en low for 7 cycles mid-period -> tick delayed by exactly 7 cycles; sync_clr asserted with en = 0 -> cnt = 0, sq = 1, tick = 0 on the next edge.
REQ-034 Reset mid-run: pull clr_n low asynchronously between edges -> tick and sq go to 0 immediately; after release, timing matches the REQ-030 scenario.
REQ-035 Width: CNT_W = 4, div_val = 15 -> period 15, cnt never exceeds 14, no wrap error.
